// File: rtl/wfifo_ingress.sv
// ---------------------------------------------------------------------------
// wfifo_ingress
//   Write-side ingress stage of the async FIFO (wclk domain). An upstream
//   valid/ready stream is absorbed by a 2-entry skid buffer and replayed as
//   winc/wdata toward the pointer/full block and the memory write port, so
//   s_ready is decoded purely from local registers and never from wfull.
//   A registered occupancy estimate (wlevel), an almost-full flag and a
//   sticky level-error flag are derived from the write gray pointer and the
//   synchronized read gray pointer.
//
// Ports
//   wclk, wrst          clock, asynchronous active-high reset
//   s_valid/s_data      upstream word offer
//   s_ready             ingress can accept a word this cycle
//   winc/wdata          write strobe and data toward pointer logic / memory
//   wfull               registered full flag from pointer/full logic
//   wptr                write gray pointer (wclk domain)
//   wq2_rptr            read gray pointer synchronized into wclk
//   wlevel              occupancy estimate, 0..2**ADDRSIZE, lags wptr by 1
//   walmost_full        wlevel >= AFULL_THRESH
//   wlevel_err          sticky: computed level exceeded 2**ADDRSIZE
// ---------------------------------------------------------------------------
module wfifo_ingress #(
  parameter int ADDRSIZE     = 8,
  parameter int DATASIZE     = 8,
  parameter int AFULL_THRESH = 252
) (
  input  logic                wclk,
  input  logic                wrst,
  input  logic                s_valid,
  input  logic [DATASIZE-1:0] s_data,
  output logic                s_ready,
  output logic                winc,
  output logic [DATASIZE-1:0] wdata,
  input  logic                wfull,
  input  logic [ADDRSIZE:0]   wptr,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                walmost_full,
  output logic                wlevel_err
);

  localparam int PW = ADDRSIZE + 1;
  localparam logic [PW-1:0] DEPTH  = PW'(2 ** ADDRSIZE);
  localparam logic [PW-1:0] THRESH = PW'(AFULL_THRESH);

  // Prefix-XOR gray to binary conversion.
  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Skid buffer state
  logic [DATASIZE-1:0] entry_q [2];
  logic                head_q, head_d;
  logic                tail_q, tail_d;
  logic [1:0]          count_q, count_d;
  logic                push, pop;

  // Level estimate state
  logic [PW-1:0] wb, rb, diff;
  logic [PW-1:0] wlevel_q;
  logic          afull_q;
  logic          err_q;

  // s_ready only looks at count_q; wfull affects winc alone.
  assign s_ready = (count_q != 2'd2);
  assign winc    = (count_q != 2'd0) & ~wfull;
  assign wdata   = entry_q[head_q];
  assign push    = s_valid & s_ready;
  assign pop     = winc;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) tail_d = ~tail_q;
    if (pop)  head_d = ~head_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (push) entry_q[tail_q] <= s_data;
    end
  end

  // Modulo subtraction handles pointer wrap without special cases.
  always_comb begin
    wb   = gray2bin(wptr);
    rb   = gray2bin(wq2_rptr);
    diff = wb - rb;
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wlevel_q <= '0;
      afull_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      wlevel_q <= diff;
      afull_q  <= (diff >= THRESH);
      if (diff > DEPTH) err_q <= 1'b1;
    end
  end

  assign wlevel       = wlevel_q;
  assign walmost_full = afull_q;
  assign wlevel_err   = err_q;

endmodule

// File: tb/tb_wfifo_ingress.sv
module tb_wfifo_ingress;

  logic       wclk = 1'b0;
  logic       wrst;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic       winc;
  logic [7:0] wdata;
  logic       wfull;
  logic [8:0] wptr;
  logic [8:0] wq2_rptr;
  logic [8:0] wlevel;
  logic       walmost_full;
  logic       wlevel_err;

  int total = 0;
  int bad   = 0;

  wfifo_ingress #(.ADDRSIZE(8), .DATASIZE(8), .AFULL_THRESH(252)) dut (
    .wclk(wclk), .wrst(wrst), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .winc(winc), .wdata(wdata), .wfull(wfull),
    .wptr(wptr), .wq2_rptr(wq2_rptr), .wlevel(wlevel),
    .walmost_full(walmost_full), .wlevel_err(wlevel_err)
  );

  always #5 wclk = ~wclk;

  function automatic logic [8:0] gray(input logic [8:0] b);
    return b ^ (b >> 1);
  endfunction

  // Advance one clock; inputs are driven and outputs sampled 1 time unit
  // after the rising edge.
  task automatic step();
    @(posedge wclk);
    #1;
  endtask

  task automatic test_reset();
    wrst = 1'b1; s_valid = 1'b0; s_data = 8'h00; wfull = 1'b0;
    wptr = '0; wq2_rptr = '0;
    #2;
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL rst_s_ready got=%b exp=1", s_ready); end
    total++; if (winc !== 1'b0) begin bad++; $display("FAIL rst_winc got=%b exp=0", winc); end
    total++; if (wdata !== 8'h00) begin bad++; $display("FAIL rst_wdata got=%h exp=00", wdata); end
    total++; if (wlevel !== 9'd0) begin bad++; $display("FAIL rst_wlevel got=%0d exp=0", wlevel); end
    total++; if (walmost_full !== 1'b0) begin bad++; $display("FAIL rst_afull got=%b exp=0", walmost_full); end
    total++; if (wlevel_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", wlevel_err); end
    step(); step();
    wrst = 1'b0;
    step();
  endtask

  task automatic test_single();
    s_valid = 1'b1; s_data = 8'hA5;
    #1;
    total++; if (winc !== 1'b0) begin bad++; $display("FAIL single_winc0 got=%b exp=0", winc); end
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL single_ready0 got=%b exp=1", s_ready); end
    step();
    s_valid = 1'b0;
    #1;
    total++; if (winc !== 1'b1) begin bad++; $display("FAIL single_winc1 got=%b exp=1", winc); end
    total++; if (wdata !== 8'hA5) begin bad++; $display("FAIL single_wdata got=%h exp=a5", wdata); end
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL single_ready1 got=%b exp=1", s_ready); end
    step();
    total++; if (winc !== 1'b0) begin bad++; $display("FAIL single_winc2 got=%b exp=0", winc); end
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL single_ready2 got=%b exp=1", s_ready); end
  endtask

  task automatic test_stream();
    s_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      s_data = 8'(i);
      step();
      total++; if (winc !== 1'b1) begin bad++; $display("FAIL stream_winc[%0d] got=%b exp=1", i, winc); end
      total++; if (wdata !== 8'(i)) begin bad++; $display("FAIL stream_wdata[%0d] got=%h exp=%h", i, wdata, 8'(i)); end
      total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL stream_ready[%0d] got=%b exp=1", i, s_ready); end
    end
    s_valid = 1'b0;
    step();
    total++; if (winc !== 1'b0) begin bad++; $display("FAIL stream_drain got=%b exp=0", winc); end
  endtask

  task automatic test_backpressure();
    wfull = 1'b1; s_valid = 1'b1; s_data = 8'h10;
    step();
    s_data = 8'h11;
    total++; if (winc !== 1'b0) begin bad++; $display("FAIL bp_winc1 got=%b exp=0", winc); end
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL bp_ready1 got=%b exp=1", s_ready); end
    step();
    s_data = 8'h12;
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL bp_ready2 got=%b exp=0", s_ready); end
    total++; if (winc !== 1'b0) begin bad++; $display("FAIL bp_winc2 got=%b exp=0", winc); end
    step();
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_hold got=%b exp=0", s_ready); end
    total++; if (wdata !== 8'h10) begin bad++; $display("FAIL bp_wdata_hold got=%h exp=10", wdata); end
    wfull = 1'b0;
    #1;
    total++; if (winc !== 1'b1) begin bad++; $display("FAIL bp_winc_release got=%b exp=1", winc); end
    total++; if (wdata !== 8'h10) begin bad++; $display("FAIL bp_wdata0 got=%h exp=10", wdata); end
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_release got=%b exp=0", s_ready); end
    step();
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_back got=%b exp=1", s_ready); end
    total++; if (wdata !== 8'h11) begin bad++; $display("FAIL bp_wdata1 got=%h exp=11", wdata); end
    step();
    s_valid = 1'b0;
    total++; if (wdata !== 8'h12) begin bad++; $display("FAIL bp_wdata2 got=%h exp=12", wdata); end
    total++; if (winc !== 1'b1) begin bad++; $display("FAIL bp_winc_last got=%b exp=1", winc); end
    step();
    total++; if (winc !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b exp=0", winc); end
  endtask

  task automatic test_level();
    wptr = gray(9'd3); wq2_rptr = gray(9'd511);
    step();
    total++; if (wlevel !== 9'd4) begin bad++; $display("FAIL lvl_wrap got=%0d exp=4", wlevel); end
    total++; if (walmost_full !== 1'b0) begin bad++; $display("FAIL lvl_wrap_af got=%b exp=0", walmost_full); end
    wptr = gray(9'd256); wq2_rptr = gray(9'd0);
    step();
    total++; if (wlevel !== 9'd256) begin bad++; $display("FAIL lvl_256 got=%0d exp=256", wlevel); end
    total++; if (walmost_full !== 1'b1) begin bad++; $display("FAIL lvl_256_af got=%b exp=1", walmost_full); end
    total++; if (wlevel_err !== 1'b0) begin bad++; $display("FAIL lvl_256_err got=%b exp=0", wlevel_err); end
    wptr = gray(9'd253);
    step();
    total++; if (walmost_full !== 1'b1) begin bad++; $display("FAIL lvl_253_af got=%b exp=1", walmost_full); end
    total++; if (wlevel !== 9'd253) begin bad++; $display("FAIL lvl_253 got=%0d exp=253", wlevel); end
    wptr = gray(9'd252);
    step();
    total++; if (walmost_full !== 1'b1) begin bad++; $display("FAIL lvl_252_af got=%b exp=1", walmost_full); end
    wptr = gray(9'd251);
    step();
    total++; if (walmost_full !== 1'b0) begin bad++; $display("FAIL lvl_251_af got=%b exp=0", walmost_full); end
    total++; if (wlevel !== 9'd251) begin bad++; $display("FAIL lvl_251 got=%0d exp=251", wlevel); end
  endtask

  task automatic test_err();
    wptr = gray(9'd300); wq2_rptr = gray(9'd0);
    step();
    total++; if (wlevel_err !== 1'b1) begin bad++; $display("FAIL err_set got=%b exp=1", wlevel_err); end
    total++; if (wlevel !== 9'd300) begin bad++; $display("FAIL err_lvl got=%0d exp=300", wlevel); end
    wptr = gray(9'd5); wq2_rptr = gray(9'd5);
    step();
    total++; if (wlevel_err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", wlevel_err); end
    total++; if (wlevel !== 9'd0) begin bad++; $display("FAIL err_lvl0 got=%0d exp=0", wlevel); end
    total++; if (walmost_full !== 1'b0) begin bad++; $display("FAIL err_af0 got=%b exp=0", walmost_full); end
  endtask

  task automatic test_reset_mid();
    wptr = gray(9'd256); wq2_rptr = gray(9'd0);
    wfull = 1'b1; s_valid = 1'b1; s_data = 8'h77;
    step();
    s_data = 8'h88;
    step();
    s_valid = 1'b0;
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL mid_full got=%b exp=0", s_ready); end
    wfull = 1'b0;
    #1;
    total++; if (winc !== 1'b1) begin bad++; $display("FAIL mid_winc_pre got=%b exp=1", winc); end
    wrst = 1'b1;
    #1;
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL mid_ready got=%b exp=1", s_ready); end
    total++; if (winc !== 1'b0) begin bad++; $display("FAIL mid_winc got=%b exp=0", winc); end
    total++; if (wdata !== 8'h00) begin bad++; $display("FAIL mid_wdata got=%h exp=00", wdata); end
    total++; if (wlevel !== 9'd0) begin bad++; $display("FAIL mid_wlevel got=%0d exp=0", wlevel); end
    total++; if (walmost_full !== 1'b0) begin bad++; $display("FAIL mid_af got=%b exp=0", walmost_full); end
    total++; if (wlevel_err !== 1'b0) begin bad++; $display("FAIL mid_err got=%b exp=0", wlevel_err); end
    wptr = '0; wq2_rptr = '0;
    step();
    wrst = 1'b0;
    s_valid = 1'b1; s_data = 8'h3C;
    step();
    s_valid = 1'b0;
    total++; if (winc !== 1'b1) begin bad++; $display("FAIL post_winc got=%b exp=1", winc); end
    total++; if (wdata !== 8'h3C) begin bad++; $display("FAIL post_wdata got=%h exp=3c", wdata); end
    step();
    total++; if (winc !== 1'b0) begin bad++; $display("FAIL post_empty got=%b exp=0", winc); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_level();
    test_err();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wfifo_ingress.md
Name: wfifo_ingress

Overview:
- Write-side ingress stage of the async FIFO. Sits directly upstream of the write-pointer/full block and the FIFO memory write port, in the wclk domain.
- Converts an upstream valid/ready stream into winc/wdata using a 2-entry skid buffer, so s_ready never depends combinationally on wfull.
- Also computes a registered write-side occupancy estimate and an almost-full flag from the write gray pointer and the synchronized read gray pointer.

Parameters:
ADDRSIZE, 8, FIFO address width; depth = 2**ADDRSIZE
DATASIZE, 8, data word width
AFULL_THRESH, 252, walmost_full asserts when wlevel >= this value (must be <= 2**ADDRSIZE)

Ports:
wclk  input  1  write-domain clock
wrst  input  1  asynchronous, active-high reset
s_valid  input  1  upstream word valid
s_data  input  DATASIZE  upstream word
s_ready  output  1  ingress can accept a word this cycle
winc  output  1  write strobe to pointer/full logic and memory
wdata  output  DATASIZE  write data to memory
wfull  input  1  registered full flag from pointer/full logic
wptr  input  ADDRSIZE+1  write gray pointer, registered, wclk domain
wq2_rptr  input  ADDRSIZE+1  read gray pointer, 2-flop synchronized into wclk
wlevel  output  ADDRSIZE+1  occupancy estimate, 0..2**ADDRSIZE
walmost_full  output  1  wlevel >= AFULL_THRESH
wlevel_err  output  1  sticky flag: computed level exceeded 2**ADDRSIZE

Behaviour:
- Clock and reset: one clock (wclk); reset is asynchronous and active-high (wrst).
- Reset values:
  - skid count = 0, so s_ready = 1 and winc = 0.
  - wdata = 0, wlevel = 0, walmost_full = 0, wlevel_err = 0.
  - Skid entries are cleared to 0.
- Skid buffer:
  - 2 entries, head/tail indices, count 0..2.
  - s_ready = (count != 2), decoded from registers only; there is no combinational path from wfull or s_valid.
  - push = s_valid & s_ready; the word is written at tail.
  - pop = winc.
  - winc = (count != 0) & ~wfull, a combinational decode of registered state plus wfull.
  - wdata = entry[head], always valid whenever winc = 1.
  - Count update: push only -> +1; pop only -> -1; push and pop together -> unchanged, with head and tail both advancing.
  - A push when count = 0 is not written through to the output in the same cycle. First winc comes 1 cycle after acceptance (latency 1).
  - Word order is preserved strictly; no word is ever dropped or duplicated.
- wfull boundary: while wfull = 1, winc = 0 and entries are held. With count = 2, s_ready = 0. When wfull drops, winc asserts in that same cycle.
- Level estimate:
  - wb = gray2bin(wptr) and rb = gray2bin(wq2_rptr), each ADDRSIZE+1 bits, using prefix-XOR conversion.
  - diff = (wb - rb) mod 2**(ADDRSIZE+1).
  - wlevel <= diff, registered, so it lags wptr by 1 cycle.
  - walmost_full <= (diff >= AFULL_THRESH), registered.
  - If diff > 2**ADDRSIZE, wlevel_err is set and held until reset; wlevel still takes the diff value.
  - Wrap-around of the pointer MSBs is handled by the modulo subtraction; no special cases.
  - The estimate is pessimistic because the read pointer is stale by the synchronizer delay; this is intended.
- Reset mid-operation: wrst asynchronously discards any buffered words and forces the reset values above. The first accept after release behaves as from cold.

Test Plan:
- Single word: s_valid = 1 with s_data = 8'hA5 for one cycle at count 0 -> next cycle winc = 1, wdata = 8'hA5; following cycle winc = 0 and s_ready = 1 throughout.
- Streaming: s_valid held with data 0,1,2,... and wfull = 0 -> winc = 1 every cycle after the first, wdata increments by 1, s_ready stays 1, count stays at 1.
- Backpressure: wfull = 1 while 3 words are offered -> 2 are accepted, s_ready = 0 with count = 2, winc = 0. Drop wfull -> winc = 1 that same cycle, words emitted in order, s_ready returns to 1 one cycle later.
- Level and wrap: wptr = gray(9'd3), wq2_rptr = gray(9'd511) -> wlevel = 4 one cycle later. wptr = gray(256), rptr = gray(0) -> wlevel = 256, walmost_full = 1. wptr = gray(253), rptr = gray(0) -> walmost_full = 1; wptr = gray(251), rptr = gray(0) -> walmost_full = 0.
- Error flag: wptr = gray(300), rptr = gray(0) -> wlevel_err = 1, and it stays 1 after the pointers return to equal values.
- Reset mid-flight: assert wrst with count = 2 -> s_ready = 1, winc = 0, wlevel = 0, all flags = 0 immediately, without waiting for a clock edge.
